// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset and clock-enable sequencer behind the video PLL.
// Debounces PLL lock, sequences downstream reset, and emits phase-aligned clock enables.
module pll_reset_sequencer #(
   parameter int unsigned LOCK_SYNC_STAGES   = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RESET_HOLD_CYCLES  = 16,
   parameter int unsigned RELOCK_TIMEOUT     = 65536,
   parameter int unsigned PLL_RESET_CYCLES   = 8,
   parameter int unsigned NUM_EN             = 2,
   parameter int unsigned EN_DIV_W           = 8,
   parameter logic [NUM_EN*EN_DIV_W-1:0] EN_DIV = {8'd1, 8'd2},
   parameter int unsigned LOSS_CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pll_lock_async,
   output logic                  pll_resetb,
   output logic                  rst_out,
   output logic                  ready,
   output logic [NUM_EN-1:0]     clk_en,
   output logic [LOSS_CNT_W-1:0] lock_loss_count,
   output logic [1:0]            state
);

   localparam logic [1:0] PLL_RST   = 2'd0;
   localparam logic [1:0] WAIT_LOCK = 2'd1;
   localparam logic [1:0] HOLD      = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   localparam int unsigned RST_W    = (PLL_RESET_CYCLES   > 1) ? $clog2(PLL_RESET_CYCLES)   : 1;
   localparam int unsigned HOLD_W   = (RESET_HOLD_CYCLES  > 1) ? $clog2(RESET_HOLD_CYCLES)  : 1;
   localparam int unsigned TMO_W    = (RELOCK_TIMEOUT     > 1) ? $clog2(RELOCK_TIMEOUT)     : 1;
   localparam int unsigned STABLE_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

   localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(PLL_RESET_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(RELOCK_TIMEOUT - 1);
   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [EN_DIV_W-1:0] DIV_ONE     = EN_DIV_W'(1);

   logic [LOCK_SYNC_STAGES-1:0] sync;
   logic                        lock_s;
   logic [1:0]                  state_nxt;
   logic [RST_W-1:0]            rst_cnt;
   logic [HOLD_W-1:0]           hold_cnt;
   logic [TMO_W-1:0]            tmo_cnt;
   logic [STABLE_W-1:0]         stable_cnt;
   logic                        state_change;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[LOCK_SYNC_STAGES-2:0], pll_lock_async};
      end
   end

   assign lock_s = sync[LOCK_SYNC_STAGES-1];

   // Lock acquisition beats the relock timeout when both land on the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         PLL_RST: begin
            if (rst_cnt == RST_LAST) begin
               state_nxt = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (lock_s && (stable_cnt == STABLE_LAST)) begin
               state_nxt = HOLD;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = PLL_RST;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = RUN;
            end
         end
         default: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
            end
         end
      endcase
   end

   assign state_change = (state_nxt != state);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= PLL_RST;
      end else begin
         state <= state_nxt;
      end
   end

   // Every state entry starts all phase counters from zero.
   always_ff @(posedge clk) begin
      if (reset || state_change) begin
         rst_cnt    <= '0;
         hold_cnt   <= '0;
         tmo_cnt    <= '0;
         stable_cnt <= '0;
      end else begin
         case (state)
            PLL_RST: begin
               rst_cnt <= rst_cnt + 1'b1;
            end
            WAIT_LOCK: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (lock_s) begin
                  stable_cnt <= stable_cnt + 1'b1;
               end else begin
                  stable_cnt <= '0;
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt + 1'b1;
            end
            default: begin
               rst_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_loss_count <= '0;
      end else if ((state == RUN) && !lock_s && (lock_loss_count != '1)) begin
         lock_loss_count <= lock_loss_count + 1'b1;
      end
   end

   assign pll_resetb = (state != PLL_RST);
   assign rst_out    = (state != RUN);
   assign ready      = (state == RUN);

   // Counters sit at zero outside RUN so every RUN entry fires all channels together.
   for (genvar i = 0; i < NUM_EN; i++) begin : g_en
      localparam logic [EN_DIV_W-1:0] DIV      = EN_DIV[i*EN_DIV_W +: EN_DIV_W];
      localparam logic [EN_DIV_W-1:0] DIV_LAST = (DIV <= DIV_ONE) ? '0 : (DIV - DIV_ONE);

      logic [EN_DIV_W-1:0] cnt;

      always_ff @(posedge clk) begin
         if (reset || (state != RUN)) begin
            cnt <= '0;
         end else if (cnt == DIV_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign clk_en[i] = (state == RUN) && (cnt == '0);
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with the small test-plan parameter set.
// Expected values are hand-derived cycle numbers relative to reset release.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_lock_async = 1'b0;
   logic       pll_resetb;
   logic       rst_out;
   logic       ready;
   logic [1:0] clk_en;
   logic [7:0] lock_loss_count;
   logic [1:0] state;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;

   pll_reset_sequencer #(
      .LOCK_SYNC_STAGES   (2),
      .LOCK_STABLE_CYCLES (8),
      .RESET_HOLD_CYCLES  (4),
      .RELOCK_TIMEOUT     (64),
      .PLL_RESET_CYCLES   (3),
      .NUM_EN             (2),
      .EN_DIV_W           (8),
      .EN_DIV             ({8'd1, 8'd3}),
      .LOSS_CNT_W         (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pll_lock_async  (pll_lock_async),
      .pll_resetb      (pll_resetb),
      .rst_out         (rst_out),
      .ready           (ready),
      .clk_en          (clk_en),
      .lock_loss_count (lock_loss_count),
      .state           (state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_pll_resetb"}, 32'(pll_resetb), 32'd0);
      check({tag, "_rst_out"}, 32'(rst_out), 32'd1);
      check({tag, "_ready"}, 32'(ready), 32'd0);
      check({tag, "_clk_en"}, 32'(clk_en), 32'd0);
      check({tag, "_loss"}, 32'(lock_loss_count), 32'd0);
   endtask

   // Lock held high: PLL_RST 0-2, WAIT_LOCK 3-10, HOLD 11-14, RUN from 15.
   task automatic check_release(input string tag, input int unsigned last);
      logic [1:0] es;
      logic [1:0] ee;
      for (int unsigned c = 0; c <= last; c++) begin
         if (c != 0) step();
         es = (c < 3) ? 2'd0 : (c < 11) ? 2'd1 : (c < 15) ? 2'd2 : 2'd3;
         ee[1] = (c >= 15);
         ee[0] = (c >= 15) && (((c - 15) % 3) == 0);
         check({tag, "_state"}, 32'(state), 32'(es));
         check({tag, "_pll_resetb"}, 32'(pll_resetb), 32'(c >= 3));
         check({tag, "_rst_out"}, 32'(rst_out), 32'(c < 15));
         check({tag, "_ready"}, 32'(ready), 32'(c >= 15));
         check({tag, "_clk_en"}, 32'(clk_en), 32'(ee));
      end
   endtask

   initial begin
      int unsigned w;
      int unsigned exp_loss;

      // Reset values and plain release with lock already high
      pll_lock_async = 1'b1;
      reset = 1'b1;
      step();
      check_reset_values("rst");
      step();
      reset = 1'b0;
      cyc = 0;
      check_release("s1", 25);

      // One-cycle lock glitch in WAIT_LOCK at stable count 5 (lock_s low in cycle 8)
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      cyc = 0;
      while (cyc < 6) step();
      pll_lock_async = 1'b0;
      step();
      pll_lock_async = 1'b1;
      while (cyc < 11) step();
      check("s3_no_early_hold", 32'(state), 32'd1);
      while (cyc < 16) step();
      check("s3_wait_last", 32'(state), 32'd1);
      step();
      check("s3_hold_entry", 32'(state), 32'd2);
      while (cyc < 20) step();
      check("s3_hold_last", 32'(state), 32'd2);
      step();
      check("s3_run", 32'(state), 32'd3);
      check("s3_loss", 32'(lock_loss_count), 32'd0);

      // Repeated 10-cycle lock drops in RUN; count saturates at 255
      for (int unsigned k = 1; k <= 300; k++) begin
         exp_loss = (k > 255) ? 255 : k;
         pll_lock_async = 1'b0;
         step();
         step();
         check("s4_ready_before_loss", 32'(ready), 32'd1);
         step();
         check("s4_ready_lost", 32'(ready), 32'd0);
         check("s4_clk_en_lost", 32'(clk_en), 32'd0);
         check("s4_loss_count", 32'(lock_loss_count), 32'(exp_loss));
         if (k == 1) begin
            check("s4_rst_out", 32'(rst_out), 32'd1);
            check("s4_state", 32'(state), 32'd1);
         end
         repeat (7) step();
         pll_lock_async = 1'b1;
         w = 0;
         while (!ready && (w < 40)) begin
            step();
            w++;
         end
         check("s4_relock_latency", w, 32'd14);
         check("s4_en_align0", 32'(clk_en), 32'd3);
         step();
         check("s4_en_align1", 32'(clk_en), 32'd2);
         step();
         check("s4_en_align2", 32'(clk_en), 32'd2);
         step();
         check("s4_en_align3", 32'(clk_en), 32'd3);
      end
      check("s4_loss_final", 32'(lock_loss_count), 32'd255);

      // One-cycle reset pulse while in RUN
      reset = 1'b1;
      step();
      check_reset_values("s6_rst");
      reset = 1'b0;
      cyc = 0;
      check_release("s6", 20);

      // Lock never asserts: 3 cycles PLL reset, 64 cycles waiting, repeating
      pll_lock_async = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      cyc = 0;
      for (int unsigned c = 0; c <= 140; c++) begin
         if (c != 0) step();
         check("s5_pll_resetb", 32'(pll_resetb), 32'((c % 67) >= 3));
         check("s5_state", 32'(state), ((c % 67) >= 3) ? 32'd1 : 32'd0);
         check("s5_rst_out", 32'(rst_out), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
